uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter IDW, default 2, width of grant_id (IDW >= clog2(NREQ)).
REQ-003 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset: rst_n, synchronous, active-low; clock CLK.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester byte pending.
REQ-006 SHALL have port req_data  input  8*NREQ  byte of requester i on bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NREQ  last byte of a packet; used only with the lock feature.
REQ-008 SHALL have port req_ready  output  NREQ  one-cycle accept pulse to the granted requester.
REQ-009 SHALL have port tx_data  output  8  byte to transmitter data input.
REQ-010 SHALL have port tx_start  output  1  one-cycle start strobe to transmitter.
REQ-011 SHALL have port tx_ready  input  1  transmitter ready, high in transmitter idle, registered low the cycle after an accepted start.
REQ-012 SHALL have port grant_id  output  IDW  index of the requester owning the current/last byte.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not in ARB.

Function
REQ-014 FSM states: ARB, ISSUE, WAIT_LO, WAIT_HI.
REQ-015 ARB: if tx_ready=1 and any req_valid bit is 1, select the winner, latch req_data of the winner into tx_data, load grant_id, go to ISSUE; otherwise stay.
REQ-016 ISSUE (exactly one cycle): tx_start=1, req_ready[grant_id]=1, all other req_ready bits 0; next state WAIT_LO.
REQ-017 WAIT_LO: stay until tx_ready=0, then go to WAIT_HI; tx_start=0.
REQ-018 WAIT_HI: stay until tx_ready=1, then go to ARB; the next grant decision is taken no earlier than the following cycle.
REQ-019 Latency: a byte whose valid is seen in ARB with tx_ready=1 gets tx_start on the next cycle.
REQ-020 Round-robin: search starts at index (last_grant+1) mod NREQ, ascending with wrap-around; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-021 last_grant updates to the winner in the ARB->ISSUE transition.
REQ-022 Requesters SHALL hold req_valid and req_data stable until req_ready; dropping valid before grant withdraws the request with no side effect.
REQ-023 tx_data and grant_id SHALL hold their values from ISSUE until the next ARB->ISSUE transition.
REQ-024 tx_start and req_ready SHALL never be high outside ISSUE; at most one req_ready bit is high in any cycle.
REQ-025 If tx_ready=0 in ARB (transmitter externally busy), no grant is made until it is 1.

Reset
REQ-026 With rst_n=0 at a rising edge: state=ARB, tx_start=0, req_ready=0, tx_data=8'h00, grant_id=0, busy=0, last_grant=NREQ-1, lock cleared.
REQ-027 Reset during ISSUE/WAIT_LO/WAIT_HI SHALL abort the byte without a further req_ready pulse; the transmitter is reset by the same rst_n.

Configuration
REQ-028 Macro UART_TX_ARB_LOCK_EN enables packet lock.
REQ-029 With UART_TX_ARB_LOCK_EN: a granted byte with req_last[grant_id]=0 sets lock; while locked, ARB grants only grant_id and waits, other requesters blocked, even if the locked requester is not valid; a granted byte with req_last=1 clears lock.
REQ-030 Without UART_TX_ARB_LOCK_EN: req_last ignored, every byte is arbitrated independently; no lock register is present.

Verification
REQ-031 After reset, req_valid=4'b0001, req_data[7:0]=8'h55, tx_ready=1 -> tx_start pulse next cycle, tx_data=8'h55, req_ready=4'b0001, grant_id=0.
REQ-032 req_valid=4'b1111 held, bytes 8'hA0..8'hA3, transmitter model dropping tx_ready for 10 cycles per byte -> grant order 0,1,2,3,0; one tx_start per byte.
REQ-033 req_valid=4'b0100 while tx_ready=0 for 20 cycles -> no tx_start until tx_ready=1, then tx_start one cycle later with requester 2's byte.
REQ-034 Assert rst_n=0 in WAIT_HI -> next cycle state ARB, busy=0, tx_start=0, req_ready=0, tx_data=8'h00.
REQ-035 LOCK_EN: requester 1 sends 3 bytes with req_last=0,0,1 while requester 0 holds valid -> grants 1,1,1 then 0.
REQ-036 LOCK_EN off, same stimulus -> grants alternate 1,0,1,0 with req_last ignored.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding bytes from NREQ requesters into a
// single UART transmitter, one byte per start/ready handshake.
//
// Optional feature: define UART_TX_ARB_LOCK_EN to enable packet lock. While a
// packet is locked, only the owning requester can be granted, until it sends
// a byte with req_last set.
//
// Ports:
//   CLK        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   [NREQ]    per-requester byte pending
//   req_data   in   [8*NREQ]  byte of requester i on bits [8i+7:8i]
//   req_last   in   [NREQ]    last byte of a packet (lock build only)
//   req_ready  out  [NREQ]    one-cycle accept pulse to the granted requester
//   tx_data    out  [8]       byte to the transmitter
//   tx_start   out            one-cycle start strobe to the transmitter
//   tx_ready   in             transmitter idle
//   grant_id   out  [IDW]     owner of the current/last byte
//   busy       out            high whenever the FSM is not in ARB
module uart_tx_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_LO = 2'd2,
    ST_WAIT_HI = 2'd3
  } state_e;

  state_e          state_q;
  logic [7:0]      tx_data_q;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  last_q;
  logic            tx_start_q;
  logic [NREQ-1:0] req_ready_q;
  logic            busy_q;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  int unsigned     cand;
  logic [NREQ-1:0] vshift;
  logic [7:0]      tx_data_d;
  logic [NREQ-1:0] req_ready_d;

`ifdef UART_TX_ARB_LOCK_EN
  logic            lock_q;
  logic            lock_d;
  logic [NREQ-1:0] lshift;
`else
  // req_last has no function without packet lock
  logic            unused_last;
  assign unused_last = ^req_last;
`endif

  // Round-robin winner: scan from last_q+1 upward with wrap-around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    vshift    = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = 32'(last_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      vshift = req_valid >> cand;
      if (!win_found && vshift[0]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    // A locked packet owner is the only candidate, even when it is not valid
    if (lock_q) begin
      vshift    = req_valid >> grant_q;
      win_found = vshift[0];
      win_idx   = grant_q;
    end
`endif
  end

  // Winner's byte, accept pulse and (lock build) new lock state
  always_comb begin
    tx_data_d   = 8'(req_data >> {win_idx, 3'b000});
    req_ready_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
`ifdef UART_TX_ARB_LOCK_EN
    lshift = req_last >> win_idx;
    lock_d = ~lshift[0];
`endif
  end

  // Control FSM; strobes default low so they exist only in ISSUE
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      tx_data_q   <= 8'h00;
      grant_q     <= '0;
      last_q      <= IDW'(NREQ - 1);
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      case (state_q)
        ST_ARB: begin
          if (tx_ready && win_found) begin
            state_q     <= ST_ISSUE;
            tx_data_q   <= tx_data_d;
            grant_q     <= win_idx;
            last_q      <= win_idx;
            tx_start_q  <= 1'b1;
            req_ready_q <= req_ready_d;
            busy_q      <= 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!tx_ready) state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_ready) begin
            state_q <= ST_ARB;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_ARB;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a simple transmitter model that drops
// tx_ready for 10 cycles after each accepted start.
module tb_uart_tx_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              CLK = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_ready;
  logic [IDW-1:0]    grant_id;
  logic              busy;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_starts = 0;
  int   n_viol   = 0;
  int   tx_cnt   = 0;
  logic tx_hold  = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Transmitter model: busy for 10 cycles after an accepted start
  always @(posedge CLK) begin
    if (!rst_n)                     tx_cnt <= 0;
    else if (tx_cnt != 0)           tx_cnt <= tx_cnt - 1;
    else if (tx_start && tx_ready)  tx_cnt <= 10;
  end
  assign tx_ready = (tx_cnt == 0) && !tx_hold;

  always @(posedge CLK) begin
    if (rst_n && tx_start) n_starts <= n_starts + 1;
  end

  // Strobe sanity: req_ready one-hot and only alongside tx_start
  always @(negedge CLK) begin
    if ($countones(req_ready) > 1 || (req_ready != '0 && !tx_start))
      n_viol <= n_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int i;
    i = 0;
    @(negedge CLK);
    while (!tx_start && i < 300) begin
      @(negedge CLK);
      i++;
    end
    chk({tag, " start"}, 32'(tx_start), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    @(negedge CLK);
    while ((busy || !tx_ready) && i < 300) begin
      @(negedge CLK);
      i++;
    end
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  logic [IDW-1:0] exp_g [4];
  logic [7:0]     exp_d [4];
  int             k;
  int             s0;
  int unsigned    gi;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge CLK);

    // Reset values
    chk("rst tx_start", 32'(tx_start), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'h00);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);

    // Single byte from requester 0, start one cycle later
    rst_n          = 1'b1;
    req_valid      = 4'b0001;
    req_data[7:0]  = 8'h55;
    @(negedge CLK);
    chk("t1 tx_start", 32'(tx_start), 32'd1);
    chk("t1 tx_data", 32'(tx_data), 32'h55);
    chk("t1 req_ready", 32'(req_ready), 32'h1);
    chk("t1 grant_id", 32'(grant_id), 32'd0);
    chk("t1 busy", 32'(busy), 32'd1);
    req_valid = '0;
    @(negedge CLK);
    chk("t1 start pulse width", 32'(tx_start), 32'd0);
    chk("t1 ready pulse width", 32'(req_ready), 32'h0);
    wait_idle("t1");

    // All four requesting: round-robin 0,1,2,3,0
    do_reset();
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gi = 32'(g % 4);
      wait_start("rr");
      chk("rr grant_id", 32'(grant_id), gi);
      chk("rr tx_data", 32'(tx_data), 32'h0A0 + gi);
      chk("rr req_ready", 32'(req_ready), 32'h1 << gi);
      if (g == 4) req_valid = '0;
    end
    wait_idle("rr");

    // Transmitter held busy: no grant until tx_ready returns
    tx_hold         = 1'b1;
    req_valid       = 4'b0100;
    req_data[23:16] = 8'hC2;
    s0 = n_starts;
    repeat (20) @(negedge CLK);
    chk("hold no start", 32'(n_starts - s0), 32'd0);
    chk("hold busy", 32'(busy), 32'd0);
    tx_hold = 1'b0;
    @(negedge CLK);
    chk("hold tx_start", 32'(tx_start), 32'd1);
    chk("hold grant_id", 32'(grant_id), 32'd2);
    chk("hold tx_data", 32'(tx_data), 32'hC2);
    req_valid = '0;
    wait_idle("hold");

    // Reset while in WAIT_HI
    req_valid     = 4'b0001;
    req_data[7:0] = 8'h77;
    wait_start("wrst");
    req_valid = '0;
    repeat (3) @(negedge CLK);
    chk("wrst busy before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge CLK);
    chk("wrst tx_start", 32'(tx_start), 32'd0);
    chk("wrst req_ready", 32'(req_ready), 32'h0);
    chk("wrst tx_data", 32'(tx_data), 32'h00);
    chk("wrst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge CLK);
    chk("wrst after busy", 32'(busy), 32'd0);
    chk("wrst after start", 32'(tx_start), 32'd0);

    // Packet from requester 1 (last=0,0,1) racing requester 0
`ifdef UART_TX_ARB_LOCK_EN
    exp_g = '{2'd1, 2'd1, 2'd1, 2'd0};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'hE0};
`else
    exp_g = '{2'd1, 2'd0, 2'd1, 2'd0};
    exp_d = '{8'h10, 8'hE0, 8'h11, 8'hE0};
`endif
    k              = 0;
    req_last       = '0;
    req_data[15:8] = 8'h10;
    req_valid      = 4'b0010;
    for (int g = 0; g < 4; g++) begin
      wait_start("pkt");
      chk("pkt grant_id", 32'(grant_id), 32'(exp_g[g]));
      chk("pkt tx_data", 32'(tx_data), 32'(exp_d[g]));
      if (g == 0) begin
        req_data[7:0] = 8'hE0;
        req_valid[0]  = 1'b1;
      end
      if (grant_id == 2'd1) begin
        k++;
        if (k == 3) req_valid[1] = 1'b0;
        else begin
          req_data[15:8] = 8'h10 + 8'(k);
          req_last[1]    = (k == 2);
        end
      end
      if (g == 3) req_valid = '0;
    end
    wait_idle("pkt");

    chk("total starts", 32'(n_starts), 32'd12);
    chk("strobe violations", 32'(n_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
